ct_vfmau_ff1_pipe: RTL and testbench



---
 rtl/ct_vfmau_ff1_pipe.sv | 166 ++++++++++++++++
 tb/tb_ct_vfmau_ff1_pipe.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_vfmau_ff1_pipe.sv
// ct_vfmau_ff1_pipe: two-stage multi-lane leading-one detector for VFMAU normalisation.
// Optional normalised-data output enabled by defining CT_VFMAU_FF1_NORM_EN.
module ct_vfmau_ff1_pipe #(
  parameter int WIDTH = 24,
  parameter int LANES = 2,
  parameter int GRP = 8,
  localparam int RW = $clog2(WIDTH + 1)
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst,
  input  logic                   ff1_flush,
  input  logic                   ff1_in_vld,
  output logic                   ff1_in_rdy,
  input  logic [LANES*WIDTH-1:0] ff1_in_data,
  output logic                   ff1_out_vld,
  input  logic                   ff1_out_rdy,
  output logic [LANES*RW-1:0]    ff1_out_result,
  output logic [LANES-1:0]       ff1_out_zero
`ifdef CT_VFMAU_FF1_NORM_EN
  ,
  output logic [LANES*WIDTH-1:0] ff1_out_norm
`endif
);

  localparam int NG = (WIDTH + GRP - 1) / GRP;
  localparam int LW = $clog2(GRP);

  logic s2_adv;
  logic s1_adv;
  logic acc;
  logic s2_load;

  logic v1_q, v1_d;
  logic v2_q, v2_d;

  logic [LANES-1:0][NG-1:0]         nz_q, nz_d;
  logic [LANES-1:0][NG-1:0][LW-1:0] idx_q, idx_d;
  logic [LANES-1:0][RW-1:0]         res_q, res_d;
  logic [LANES-1:0]                 zero_q, zero_d;

  logic [WIDTH-1:0] s1_lane;
  logic [WIDTH-1:0] s1_sh;
  int               s1_pos;
  int               s2_pos;

`ifdef CT_VFMAU_FF1_NORM_EN
  logic [LANES-1:0][WIDTH-1:0] dat_q, dat_d;
  logic [LANES-1:0][WIDTH-1:0] norm_q, norm_d;
`endif

  // Handshake: each stage advances when the one downstream frees up
  always_comb begin
    s2_adv     = !v2_q || ff1_out_rdy;
    s1_adv     = !v1_q || s2_adv;
    ff1_in_rdy = s1_adv && !ff1_flush && !cpurst;
    acc        = ff1_in_vld && ff1_in_rdy;
    s2_load    = s2_adv && v1_q;
  end

  // Stage valid bits; flush empties both stages on the same edge
  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    if (s2_adv) v2_d = v1_q;
    if (s1_adv) v1_d = acc;
    if (ff1_flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end
  end

  // S1: per MSB-aligned group, nonzero flag and local first-one index
  always_comb begin
    nz_d    = nz_q;
    idx_d   = idx_q;
    s1_lane = '0;
    s1_sh   = '0;
    s1_pos  = 0;
    if (acc) begin
      for (int l = 0; l < LANES; l++) begin
        s1_lane = WIDTH'(ff1_in_data >> (l * WIDTH));
        for (int g = 0; g < NG; g++) begin
          nz_d[l][g]  = 1'b0;
          idx_d[l][g] = '0;
          for (int b = GRP - 1; b >= 0; b--) begin
            s1_pos = WIDTH - 1 - g * GRP - b;
            if (s1_pos >= 0) begin
              s1_sh = s1_lane >> s1_pos;
              if (s1_sh[0]) begin
                nz_d[l][g]  = 1'b1;
                idx_d[l][g] = LW'(b);
              end
            end
          end
        end
      end
    end
  end

`ifdef CT_VFMAU_FF1_NORM_EN
  // S1 raw data copy feeding the S2 shifter
  always_comb begin
    dat_d = dat_q;
    if (acc) dat_d = ff1_in_data;
  end
`endif

  // S2: most significant nonzero group wins; load only on a valid move
  always_comb begin
    res_d  = res_q;
    zero_d = zero_q;
    s2_pos = 0;
`ifdef CT_VFMAU_FF1_NORM_EN
    norm_d = norm_q;
`endif
    if (s2_load) begin
      for (int l = 0; l < LANES; l++) begin
        s2_pos = 0;
        for (int g = NG - 1; g >= 0; g--) begin
          if (nz_q[l][g]) s2_pos = g * GRP + int'(idx_q[l][g]) + 1;
        end
        res_d[l]  = RW'(s2_pos);
        zero_d[l] = ~|nz_q[l];
`ifdef CT_VFMAU_FF1_NORM_EN
        if (s2_pos == 0) norm_d[l] = '0;
        else             norm_d[l] = dat_q[l] << (s2_pos - 1);
`endif
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      nz_q   <= '0;
      idx_q  <= '0;
      res_q  <= '0;
      zero_q <= '0;
`ifdef CT_VFMAU_FF1_NORM_EN
      dat_q  <= '0;
      norm_q <= '0;
`endif
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      nz_q   <= nz_d;
      idx_q  <= idx_d;
      res_q  <= res_d;
      zero_q <= zero_d;
`ifdef CT_VFMAU_FF1_NORM_EN
      dat_q  <= dat_d;
      norm_q <= norm_d;
`endif
    end
  end

  assign ff1_out_vld    = v2_q;
  assign ff1_out_result = res_q;
  assign ff1_out_zero   = zero_q;
`ifdef CT_VFMAU_FF1_NORM_EN
  assign ff1_out_norm   = norm_q;
`endif

endmodule

// File: tb/tb_ct_vfmau_ff1_pipe.sv
// tb_ct_vfmau_ff1_pipe: randomized and directed bench for ct_vfmau_ff1_pipe.
// Also exercises a 10-bit, group-of-4 instance against the legacy ff1 positions.
module tb_ct_vfmau_ff1_pipe;

  localparam int W  = 24;
  localparam int L  = 2;
  localparam int G  = 8;
  localparam int RW = $clog2(W + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           in_vld = 1'b0;
  logic           out_rdy = 1'b0;
  logic [L*W-1:0] in_data = '0;
  logic           in_rdy;
  logic           out_vld;
  logic [L*RW-1:0] res;
  logic [L-1:0]   zero;

  logic           v_flush = 1'b0;
  logic           v_in_vld = 1'b0;
  logic           v_out_rdy = 1'b1;
  logic [9:0]     v_data = '0;
  logic           v_in_rdy;
  logic           v_out_vld;
  logic [3:0]     v_res;
  logic           v_zero;

`ifdef CT_VFMAU_FF1_NORM_EN
  logic [L*W-1:0] norm;
  logic [9:0]     v_norm;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ct_vfmau_ff1_pipe #(.WIDTH(W), .LANES(L), .GRP(G)) dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .ff1_flush      (flush),
    .ff1_in_vld     (in_vld),
    .ff1_in_rdy     (in_rdy),
    .ff1_in_data    (in_data),
    .ff1_out_vld    (out_vld),
    .ff1_out_rdy    (out_rdy),
    .ff1_out_result (res),
    .ff1_out_zero   (zero)
`ifdef CT_VFMAU_FF1_NORM_EN
    ,
    .ff1_out_norm   (norm)
`endif
  );

  ct_vfmau_ff1_pipe #(.WIDTH(10), .LANES(1), .GRP(4)) u10 (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .ff1_flush      (v_flush),
    .ff1_in_vld     (v_in_vld),
    .ff1_in_rdy     (v_in_rdy),
    .ff1_in_data    (v_data),
    .ff1_out_vld    (v_out_vld),
    .ff1_out_rdy    (v_out_rdy),
    .ff1_out_result (v_res),
    .ff1_out_zero   (v_zero)
`ifdef CT_VFMAU_FF1_NORM_EN
    ,
    .ff1_out_norm   (v_norm)
`endif
  );

  // Reference: walk from the MSB, count positions until the first one
  function automatic int ref_pos(input logic [W-1:0] d);
    logic [W-1:0] t;
    t = d;
    for (int i = 0; i < W; i++) begin
      if (t[W-1]) return i + 1;
      t = t << 1;
    end
    return 0;
  endfunction

  function automatic logic [W-1:0] lane_of(input logic [L*W-1:0] d, input int l);
    return W'(d >> (l * W));
  endfunction

  function automatic logic [L*RW-1:0] exp_res(input logic [L*W-1:0] d);
    logic [L*RW-1:0] r;
    r = '0;
    for (int l = 0; l < L; l++)
      r = r | ((L*RW)'(ref_pos(lane_of(d, l))) << (l * RW));
    return r;
  endfunction

  function automatic logic [L-1:0] exp_zero(input logic [L*W-1:0] d);
    logic [L-1:0] z;
    z = '0;
    for (int l = 0; l < L; l++)
      if (lane_of(d, l) == '0) z = z | (L'(1) << l);
    return z;
  endfunction

  function automatic logic [L*W-1:0] exp_norm(input logic [L*W-1:0] d);
    logic [L*W-1:0] r;
    logic [W-1:0]   x;
    int             p;
    r = '0;
    for (int l = 0; l < L; l++) begin
      x = lane_of(d, l);
      p = ref_pos(x);
      if (p != 0) x = x << (p - 1);
      r = r | ((L*W)'(x) << (l * W));
    end
    return r;
  endfunction

  function automatic logic [L*W-1:0] rnd_data();
    logic [L*W-1:0] r;
    logic [W-1:0]   x;
    r = '0;
    for (int l = 0; l < L; l++) begin
      x = W'($urandom) >> $urandom_range(0, W);
      r = r | ((L*W)'(x) << (l * W));
    end
    return r;
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_vld: got %b expected 0", out_vld);
    end
    checks++;
    if (res !== '0 || zero !== '0) begin
      errors++;
      $display("FAIL reset_result: got %h/%b expected 0/0", res, zero);
    end
    checks++;
    if (in_rdy !== 1'b0 || v_in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_rdy: got %b/%b expected 0/0", in_rdy, v_in_rdy);
    end
`ifdef CT_VFMAU_FF1_NORM_EN
    checks++;
    if (norm !== '0) begin
      errors++;
      $display("FAIL reset_norm: got %h expected 0", norm);
    end
`endif
    rst = 1'b0;
    #1;
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL release_in_rdy: got %b expected 1", in_rdy);
    end
  endtask

  task automatic test_directed(input logic [L*W-1:0] d,
                               input logic [L*RW-1:0] er,
                               input logic [L-1:0] ez,
                               input logic [L*W-1:0] en);
    @(negedge clk);
    in_vld  = 1'b1;
    in_data = d;
    out_rdy = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    #1;
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL dir_early_vld: got %b expected 0", out_vld);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_vld !== 1'b1 || res !== er || zero !== ez) begin
      errors++;
      $display("FAIL dir_result: got v=%b r=%h z=%b expected v=1 r=%h z=%b",
               out_vld, res, zero, er, ez);
    end
`ifdef CT_VFMAU_FF1_NORM_EN
    checks++;
    if (norm !== en) begin
      errors++;
      $display("FAIL dir_norm: got %h expected %h", norm, en);
    end
`else
    if (en != en) $display("unreachable");
`endif
  endtask

  task automatic test_legacy10();
    logic [9:0] one;
    logic [9:0] d;
    one = 10'd1;
    for (int b = 10; b >= 0; b--) begin
      @(negedge clk);
      if (b == 10) d = '0;
      else d = (one << b) | (10'($urandom) & ((one << b) - 10'd1));
      v_in_vld = 1'b1;
      v_data   = d;
      @(negedge clk);
      v_in_vld = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (b == 10) begin
        if (v_out_vld !== 1'b1 || v_res !== 4'd0 || v_zero !== 1'b1) begin
          errors++;
          $display("FAIL w10_zero: got v=%b r=%0d z=%b expected v=1 r=0 z=1",
                   v_out_vld, v_res, v_zero);
        end
      end else begin
        if (v_out_vld !== 1'b1 || v_res !== 4'(10 - b) || v_zero !== 1'b0) begin
          errors++;
          $display("FAIL w10_bit%0d: got v=%b r=%0d z=%b expected v=1 r=%0d z=0",
                   b, v_out_vld, v_res, v_zero, 10 - b);
        end
      end
`ifdef CT_VFMAU_FF1_NORM_EN
      checks++;
      if (b != 10 && v_norm !== 10'(d << (9 - b))) begin
        errors++;
        $display("FAIL w10_norm%0d: got %h expected %h", b, v_norm, 10'(d << (9 - b)));
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [L*W-1:0]  dat [8];
    logic [L*RW-1:0] rec [$];
    logic [L*RW-1:0] hold;
    int              sent;
    sent = 0;
    hold = '0;
    for (int i = 0; i < 8; i++) dat[i] = rnd_data();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_vld  = (sent < 8);
      in_data = (sent < 8) ? dat[sent] : '0;
      out_rdy = !(c >= 3 && c <= 6);
      #1;
      if (c == 3) hold = res;
      if (c == 4) begin
        checks++;
        if (in_rdy !== 1'b0 || out_vld !== 1'b1) begin
          errors++;
          $display("FAIL b2b_stall: got in_rdy=%b out_vld=%b expected 0/1", in_rdy, out_vld);
        end
      end
      if (c == 6) begin
        checks++;
        if (out_vld !== 1'b1 || res !== hold) begin
          errors++;
          $display("FAIL b2b_hold: got v=%b r=%h expected v=1 r=%h", out_vld, res, hold);
        end
      end
      if (out_vld && out_rdy) rec.push_back(res);
      if (in_vld && in_rdy) sent++;
    end
    in_vld = 1'b0;
    checks++;
    if (rec.size() != 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 8", rec.size());
    end
    for (int i = 0; i < 8 && i < rec.size(); i++) begin
      checks++;
      if (rec[i] !== exp_res(dat[i])) begin
        errors++;
        $display("FAIL b2b_order%0d: got %h expected %h", i, rec[i], exp_res(dat[i]));
      end
    end
  endtask

  task automatic test_random_stream();
    logic [L*W-1:0] q [$];
    logic [L*W-1:0] e;
    logic           stall;
    stall = 1'b0;
    for (int c = 0; c < 320; c++) begin
      @(negedge clk);
      in_vld  = (c < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data = rnd_data();
      out_rdy = (c < 300) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      checks++;
      if (in_rdy !== (q.size() < 2 || out_rdy)) begin
        errors++;
        $display("FAIL rnd_in_rdy c%0d: got %b inflight=%0d out_rdy=%b",
                 c, in_rdy, q.size(), out_rdy);
      end
      if (stall) begin
        checks++;
        if (out_vld !== 1'b1) begin
          errors++;
          $display("FAIL rnd_hold_vld c%0d: got %b expected 1", c, out_vld);
        end
      end
      if (out_vld) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_spurious c%0d: got out_vld=1 expected nothing pending", c);
        end else begin
          e = q[0];
          if (res !== exp_res(e) || zero !== exp_zero(e)) begin
            errors++;
            $display("FAIL rnd_result c%0d: got %h/%b expected %h/%b",
                     c, res, zero, exp_res(e), exp_zero(e));
          end
`ifdef CT_VFMAU_FF1_NORM_EN
          checks++;
          if (norm !== exp_norm(e)) begin
            errors++;
            $display("FAIL rnd_norm c%0d: got %h expected %h", c, norm, exp_norm(e));
          end
`endif
        end
      end
      stall = out_vld && !out_rdy;
      if (out_vld && out_rdy && q.size() > 0) void'(q.pop_front());
      if (in_vld && in_rdy) q.push_back(in_data);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rnd_drain: got %0d pending expected 0", q.size());
    end
  endtask

  task automatic test_flush();
    logic [L*W-1:0] d;
    d = rnd_data();
    @(negedge clk);
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_data = rnd_data();
    @(negedge clk);
    in_data = rnd_data();
    @(negedge clk);
    in_data = rnd_data();
    flush   = 1'b1;
    #1;
    checks++;
    if (in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_rdy: got %b expected 0", in_rdy);
    end
    @(negedge clk);
    flush   = 1'b0;
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    #1;
    checks++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL flush_after: got out_vld=%b in_rdy=%b expected 0/1", out_vld, in_rdy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_vld !== 1'b0) begin
        errors++;
        $display("FAIL flush_leak%0d: got out_vld=%b expected 0", i, out_vld);
      end
    end
    @(negedge clk);
    in_vld  = 1'b1;
    in_data = d;
    @(negedge clk);
    in_vld = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (out_vld !== 1'b1 || res !== exp_res(d) || zero !== exp_zero(d)) begin
      errors++;
      $display("FAIL flush_resume: got v=%b r=%h expected v=1 r=%h", out_vld, res, exp_res(d));
    end
  endtask

  task automatic test_midreset();
    logic [L*W-1:0] d;
    d = rnd_data();
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_vld  = 1'b1;
      in_data = rnd_data();
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL mrst_in_rdy: got %b expected 0", in_rdy);
    end
    @(negedge clk);
    rst     = 1'b0;
    in_data = d;
    #1;
    checks++;
    if (out_vld !== 1'b0 || res !== '0 || zero !== '0 || in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL mrst_clear: got v=%b r=%h z=%b rdy=%b expected 0/0/0/1",
               out_vld, res, zero, in_rdy);
    end
`ifdef CT_VFMAU_FF1_NORM_EN
    checks++;
    if (norm !== '0) begin
      errors++;
      $display("FAIL mrst_norm: got %h expected 0", norm);
    end
`endif
    @(negedge clk);
    in_vld = 1'b0;
    #1;
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL mrst_early: got %b expected 0", out_vld);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_vld !== 1'b1 || res !== exp_res(d) || zero !== exp_zero(d)) begin
      errors++;
      $display("FAIL mrst_first: got v=%b r=%h expected v=1 r=%h", out_vld, res, exp_res(d));
    end
  endtask

  initial begin
    test_reset();
    test_directed({24'h000001, 24'h800000}, {5'd24, 5'd1}, 2'b00,
                  {24'h800000, 24'h800000});
    test_directed({24'h001000, 24'h000000}, {5'd12, 5'd0}, 2'b01,
                  {24'h800000, 24'h000000});
    test_legacy10();
    test_back_to_back();
    test_random_stream();
    test_flush();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
